reg_file: RTL

- 8-entry x 8-bit register file that acts as the operand source and result sink for the datapath ALU.
- Two combinational read ports drive the ALU's DATA1 and DATA2 inputs.
- One clocked write port accepts the ALU RESULT.
- Includes synchronous clear and a write-commit strobe for the control unit, plus a per-register written mask for debug and verification.

---
 rtl/reg_file.sv | 62 ++++++
 1 files changed

// File: rtl/reg_file.sv
// 8 x 8 register file feeding the ALU: two combinational read ports, one clocked
// write port, a write-commit pulse and a per-register "written since reset" mask.
module reg_file #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WRITE,
    input  logic [AW-1:0]    INADDRESS,
    input  logic [WIDTH-1:0] IN,
    input  logic [AW-1:0]    OUT1ADDRESS,
    input  logic [AW-1:0]    OUT2ADDRESS,
    output logic [WIDTH-1:0] OUT1,
    output logic [WIDTH-1:0] OUT2,
    output logic             WRITE_DONE,
    output logic [DEPTH-1:0] WRITTEN
);

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0] written_q;
    logic [DEPTH-1:0] written_d;
    logic             done_q;
    logic             done_d;

    // IN and INADDRESS are only looked at when WRITE is high, so junk on them
    // during idle cycles never reaches the state.
    always_comb begin
        regs_d    = regs_q;
        written_d = written_q;
        done_d    = 1'b0;
        if (WRITE) begin
            regs_d[INADDRESS]    = IN;
            written_d[INADDRESS] = 1'b1;
            done_d               = 1'b1;
        end
    end

    // Reset wins over a simultaneous write: the write and its done pulse are dropped.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            written_q <= '0;
            done_q    <= 1'b0;
        end else begin
            regs_q    <= regs_d;
            written_q <= written_d;
            done_q    <= done_d;
        end
    end

    // No write bypass: a read of the address being written shows the old value.
    assign OUT1       = regs_q[OUT1ADDRESS];
    assign OUT2       = regs_q[OUT2ADDRESS];
    assign WRITE_DONE = done_q;
    assign WRITTEN    = written_q;

endmodule
